seg7_serial_out: RTL
====================

Name: seg7_serial_out

Overview:
- Downstream consumer of the 8-channel display multiplexer.
- Takes the selected 32-bit display word, the 8-bit per-digit blank mask and the 8-bit per-digit decimal-point mask.
- Encodes them into eight 7-segment bytes and shifts the resulting 64-bit frame into the board's serial-in/parallel-out shift-register chain.
- Provides a shift clock, serial data and a latch strobe, plus an optional auto-refresh whenever the displayed content changes.

Parameters:
- CLK_DIV, 2: number of clk cycles in each half-period of seg_clk; legal range 1..255.
- AUTO_REFRESH, 1: when 1, the block self-starts a frame whenever the sampled inputs differ from the last frame sent.

Ports:
- clk  input  1  system clock; every register is clocked on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to send a frame.
- Disp_num  input  32  display word; nibble i drives digit i, digit 0 is rightmost.
- LE  input  8  LE[i]=1 blanks digit i.
- point  input  8  point[i]=1 lights the decimal point of digit i.
- busy  output  1  high while a frame is being sent.
- done  output  1  one-cycle pulse when a frame completes.
- seg_clk  output  1  shift clock to the register chain.
- seg_sout  output  1  serial data; changes only while seg_clk is low.
- seg_pen  output  1  latch strobe; active high.

Behaviour:
- Reset values: busy=0, done=0, seg_clk=0, seg_sout=0, seg_pen=0, state=IDLE. The last-sent snapshot resets to Disp_num=0, LE=8'hFF, point=0.
- Segment byte format, active-low: {dp,g,f,e,d,c,b,a}.
  - Hex codes 0-F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
  - A blanked digit encodes as 8'hFF, and the blank mask also suppresses the dp.
  - A lit dp clears bit 7 of the byte.
- Frame layout: 64 bits ordered {digit7 byte, ..., digit0 byte}, shifted out MSB first. Bit 63 is sent first.
- Trigger: a frame starts at a clock edge in IDLE when either condition holds:
  - start=1, or
  - AUTO_REFRESH=1 and {Disp_num,LE,point} differs from the last-sent snapshot.
- On the trigger edge:
  - The encoded frame is loaded into the 64-bit shift register.
  - The raw inputs are stored as the last-sent snapshot.
  - The FSM enters SHIFT; busy=1 from the next cycle.
- FSM states: IDLE -> SHIFT -> LATCH -> IDLE.
- SHIFT:
  - Each bit takes 2*CLK_DIV cycles: CLK_DIV cycles with seg_clk=0, then CLK_DIV cycles with seg_clk=1.
  - seg_sout = shreg[63], stable across the whole bit.
  - At the end of the high phase, shreg shifts left by 1 and the bit counter (63->0) decrements.
  - After bit 0 completes, the FSM goes to LATCH with seg_clk=0.
- LATCH: seg_pen=1 for CLK_DIV cycles, then IDLE. done=1 for exactly the first IDLE cycle.
- Busy duration: 129*CLK_DIV cycles (258 for the default).
- A start pulse while busy is ignored, not queued. Input changes during a frame are caught by the snapshot comparison after return to IDLE.
- A trigger on the same cycle as done is accepted; back-to-back frames are separated by exactly one IDLE cycle.
- Reset mid-frame: all outputs return to reset values on the next edge, with no latch strobe. The snapshot is reset too, so with AUTO_REFRESH=1 a fresh frame starts right after reset unless the inputs equal the reset snapshot.
- seg_pen is never high while seg_clk is high.

Decomposition:
- Package seg7_pkg holds:
  - the state enum (IDLE, SHIFT, LATCH);
  - the 16-entry active-low segment constant table;
  - the SEG_BLANK = 8'hFF constant;
  - FRAME_BITS = 64.
- Sub-module hex_to_seg7 is combinational: 4-bit nibble, blank and dp in; 8-bit segment byte out. It is instantiated 8 times.

Test Plan:
1. Reset, then start with Disp_num=0, LE=0, point=0, CLK_DIV=2 -> 64 sampled bits on seg_clk rising edges equal C0C0C0C0C0C0C0C0. busy is high for 258 cycles, seg_pen is high for 2 cycles, then done pulses once.
2. Disp_num=32'h1234ABCD, LE=0, point=8'h01 -> frame F9 A4 B0 99 88 83 C6 21 (digit0 dp lit).
3. LE=8'hF0, Disp_num=32'h8888_8888, point=8'hFF -> frame FF FF FF FF 00 00 00 00.
4. AUTO_REFRESH=1, hold inputs constant after one frame -> no further frame. Change Disp_num by one bit -> exactly one new frame starts.
5. Pulse start at cycle 100 of a frame -> ignored: only one frame, one done. Assert start in the done cycle -> second frame begins after exactly one IDLE cycle.
6. Assert rst during bit 30 of SHIFT -> next cycle busy=0, seg_clk=0, seg_pen=0; no latch strobe occurs.

Source files
------------

// File: rtl/seg7_serial_out_pkg.sv
// rtl/seg7_serial_out_pkg.sv - shared types and constants for the 7-segment serial driver
// Purpose : FSM state enum, active-low hex segment table, blank code, frame size.
// Contents: state_t, FRAME_BITS, SEG_BLANK, SEG_TABLE, seg_code()
package seg7_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

   localparam int FRAME_BITS = 64;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Entry n sits in bits [8n+7:8n]; byte format {dp,g,f,e,d,c,b,a}, active low.
   localparam logic [127:0] SEG_TABLE = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

   function automatic logic [7:0] seg_code(input logic [3:0] nib);
      return SEG_TABLE[{nib, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/seg7_serial_out_if.sv
// rtl/seg7_serial_out_if.sv - serial link to the display shift-register chain
// Purpose : bundles shift clock, serial data and latch strobe.
// Signals : seg_clk (shift clock), seg_sout (serial data), seg_pen (latch strobe)
// Modports: master drives the chain, slave observes it
interface seg7_serial_out_if;

   logic seg_clk;
   logic seg_sout;
   logic seg_pen;

   modport master (output seg_clk, output seg_sout, output seg_pen);
   modport slave  (input  seg_clk, input  seg_sout, input  seg_pen);

endinterface

// File: rtl/seg7_serial_out_hex_to_seg7.sv
// rtl/seg7_serial_out_hex_to_seg7.sv - combinational hex digit to active-low segment byte
// Purpose: one digit of the frame encoder.
// Ports  : i_nib (hex digit), i_blank (blank digit and dp), i_dp (light dp),
//          o_seg ({dp,g,f,e,d,c,b,a}, active low)
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] i_nib,
   input  logic       i_blank,
   input  logic       i_dp,
   output logic [7:0] o_seg
);

   logic [7:0] w_code;

   always_comb begin
      w_code = seg_code(i_nib);
      if (i_blank) begin
         o_seg = SEG_BLANK;
      end else begin
         // Table entries all carry dp off (bit 7 = 1); a lit dp pulls it low.
         o_seg = {w_code[7] & ~i_dp, w_code[6:0]};
      end
   end

endmodule

// File: rtl/seg7_serial_out.sv
// rtl/seg7_serial_out.sv - encodes 8 hex digits and shifts the 64-bit frame to a SIPO chain
// Purpose: frame encoder, bit-serial shifter with divided shift clock, latch strobe,
//          optional auto-refresh when the inputs differ from the last frame sent.
// Ports  : clk, rst (sync, active high), start (frame request), Disp_num (8 nibbles,
//          digit 0 rightmost), LE (blank mask), point (dp mask), busy, done (1-cycle pulse),
//          seg (serial link: seg_clk, seg_sout, seg_pen)
module seg7_serial_out
   import seg7_pkg::*;
#(
   parameter int CLK_DIV      = 2,
   parameter bit AUTO_REFRESH = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [31:0]              Disp_num,
   input  logic [7:0]               LE,
   input  logic [7:0]               point,
   output logic                     busy,
   output logic                     done,
   seg7_serial_out_if.master        seg
);

   localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [5:0]  BIT_LAST = 6'(FRAME_BITS - 1);
   localparam logic [47:0] SNAP_RST = {32'h0000_0000, 8'hFF, 8'h00};

   state_t                  r_state;
   logic [FRAME_BITS-1:0]   r_shreg;
   logic [47:0]             r_snap;
   logic [7:0]              r_div_cnt;
   logic [5:0]              r_bit_cnt;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_seg_clk;
   logic                    r_seg_sout;
   logic                    r_seg_pen;

   logic [FRAME_BITS-1:0]   w_frame;
   logic [47:0]             w_inputs;
   logic                    w_trig;

   // Digit i lands in frame byte i so digit 7 leads the MSB-first shift.
   for (genvar g = 0; g < 8; g++) begin : g_enc
      hex_to_seg7 u_enc (
         .i_nib   (Disp_num[g*4 +: 4]),
         .i_blank (LE[g]),
         .i_dp    (point[g]),
         .o_seg   (w_frame[g*8 +: 8])
      );
   end

   assign w_inputs = {Disp_num, LE, point};
   assign w_trig   = start | (AUTO_REFRESH && (w_inputs != r_snap));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_shreg    <= '0;
         r_snap     <= SNAP_RST;
         r_div_cnt  <= '0;
         r_bit_cnt  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_seg_clk  <= 1'b0;
         r_seg_sout <= 1'b0;
         r_seg_pen  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (w_trig) begin
                  r_state    <= SHIFT;
                  r_shreg    <= w_frame;
                  r_snap     <= w_inputs;
                  r_div_cnt  <= '0;
                  r_bit_cnt  <= BIT_LAST;
                  r_busy     <= 1'b1;
                  r_seg_clk  <= 1'b0;
                  r_seg_sout <= w_frame[FRAME_BITS-1];
               end
            end

            SHIFT: begin
               if (r_div_cnt != DIV_LAST) begin
                  r_div_cnt <= r_div_cnt + 8'd1;
               end else if (!r_seg_clk) begin
                  r_div_cnt <= '0;
                  r_seg_clk <= 1'b1;
               end else begin
                  // End of the high phase closes the current bit.
                  r_div_cnt <= '0;
                  r_seg_clk <= 1'b0;
                  if (r_bit_cnt == 6'd0) begin
                     r_state   <= LATCH;
                     r_seg_pen <= 1'b1;
                  end else begin
                     r_shreg    <= {r_shreg[FRAME_BITS-2:0], 1'b0};
                     r_seg_sout <= r_shreg[FRAME_BITS-2];
                     r_bit_cnt  <= r_bit_cnt - 6'd1;
                  end
               end
            end

            LATCH: begin
               if (r_div_cnt != DIV_LAST) begin
                  r_div_cnt <= r_div_cnt + 8'd1;
               end else begin
                  r_div_cnt <= '0;
                  r_state   <= IDLE;
                  r_seg_pen <= 1'b0;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy         = r_busy;
   assign done         = r_done;
   assign seg.seg_clk  = r_seg_clk;
   assign seg.seg_sout = r_seg_sout;
   assign seg.seg_pen  = r_seg_pen;

endmodule
